fpa_result_packer: RTL

Downstream stage of the 8-bit minifloat adder (1 sign, 4 exp, 3 mant). Captures each finished result from the adder data path/controller when it is flagged done. Applies exception-driven special-value encoding and packs an 8-bit word. Buffers words in a small FIFO with a valid/ready output handshake, and keeps sticky status flags plus a result counter.

---
 rtl/fpa_pkg.sv | 39 +++
 rtl/fpa_result_packer_if.sv | 35 +++
 rtl/fpa_sync_fifo.sv | 62 ++++++
 rtl/fpa_result_packer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fpa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpa_pkg
//  Description : Shared field widths, constants and result class encoding
//                for the 8-bit minifloat (1 sign, 4 exp, 3 mant) adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpa_pkg;

    localparam int EXP_W   = 4;
    localparam int MANT_W  = 3;
    localparam int WORD_W  = 8;
    localparam int CLASS_W = 3;

    localparam logic [EXP_W-1:0]  EXP_MAX   = 4'hF;
    localparam logic [WORD_W-1:0] CANON_NAN = 8'b0_1111_100;

    // Bit positions inside the 4-bit exception vector from the data path
    localparam int EXC_ZERO   = 3;
    localparam int EXC_OVF    = 2;
    localparam int EXC_UFL    = 1;
    localparam int EXC_INFNAN = 0;

    typedef enum logic [CLASS_W-1:0] {
        CLS_NORMAL = 3'd0,
        CLS_ZERO   = 3'd1,
        CLS_INF    = 3'd2,
        CLS_NAN    = 3'd3,
        CLS_UFLOW  = 3'd4
    } fpa_class_e;

    // One FIFO entry: class tag above the packed word (11 bits)
    typedef struct packed {
        fpa_class_e        cls;
        logic [WORD_W-1:0] word;
    } fpa_entry_t;

endpackage
`default_nettype wire

// File: rtl/fpa_result_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpa_result_packer_if
//  Description : Input (adder done strobe) and output (valid/ready) bundle
//                of the result packer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpa_result_packer_if;
    import fpa_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_sign;
    logic [EXP_W-1:0]    in_exp;
    logic [MANT_W-1:0]   in_mant;
    logic [3:0]          in_except;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_data;
    logic [CLASS_W-1:0]  out_class;

    // Producer of results and consumer of packed words
    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_except, out_ready,
        input  in_ready, out_valid, out_data, out_class
    );

    // The packer itself
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_except, out_ready,
        output in_ready, out_valid, out_data, out_class
    );

endinterface
`default_nettype wire

// File: rtl/fpa_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpa_sync_fifo
//  Description : Small synchronous FIFO with occupancy count. Head entry is
//                presented combinationally from storage (no bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
module fpa_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  wire logic             clk,
    input  wire logic             clr,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage write; cleared on reset so the head reads zero when empty
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fpa_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fpa_result_packer
//  Description : Captures finished adder results, applies special-value
//                encoding, buffers packed words in a FIFO and keeps sticky
//                status plus an accepted-result counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpa_result_packer
    import fpa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             clr,
    fpa_result_packer_if.slave    bus,
    input  wire logic             clr_sts,
    output logic [4:0]            sts,
    output logic [CNT_W-1:0]      res_cnt
);

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [WORD_W-1:0] w_enc_word;
    fpa_class_e        w_enc_class;
    fpa_entry_t        w_wr_entry;
    fpa_entry_t        w_rd_entry;
    logic [4:0]        w_sts_set;
    logic [4:0]        r_sts;
    logic [CNT_W-1:0]  r_res_cnt;
    logic              w_unused_infnan;

    // Classification is derived from the exponent field, not this flag
    assign w_unused_infnan = bus.in_except[EXC_INFNAN];

    assign w_push = bus.in_valid  & ~w_full;
    assign w_pop  = bus.out_valid & bus.out_ready;

    // Special-value encoding, first matching condition wins
    always_comb begin
        w_enc_word  = {bus.in_sign, bus.in_exp, bus.in_mant};
        w_enc_class = CLS_NORMAL;
        if (bus.in_except[EXC_ZERO]) begin
            w_enc_word  = '0;
            w_enc_class = CLS_ZERO;
        end else if (bus.in_except[EXC_OVF]) begin
            w_enc_word  = {bus.in_sign, EXP_MAX, {MANT_W{1'b0}}};
            w_enc_class = CLS_INF;
        end else if (bus.in_exp == EXP_MAX && bus.in_mant != '0) begin
            w_enc_word  = CANON_NAN;
            w_enc_class = CLS_NAN;
        end else if (bus.in_exp == EXP_MAX) begin
            w_enc_word  = {bus.in_sign, EXP_MAX, {MANT_W{1'b0}}};
            w_enc_class = CLS_INF;
        end else if (bus.in_except[EXC_UFL]) begin
            w_enc_word  = {bus.in_sign, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
            w_enc_class = CLS_UFLOW;
        end
    end

    assign w_wr_entry.cls  = w_enc_class;
    assign w_wr_entry.word = w_enc_word;

    fpa_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fpa_entry_t))
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wr_entry),
        .rdata (w_rd_entry),
        .full  (w_full),
        .empty (w_empty)
    );

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_rd_entry.word;
    assign bus.out_class = w_rd_entry.cls;

    // Status bits raised this cycle: overrun plus the class of a pushed word
    always_comb begin
        w_sts_set    = '0;
        w_sts_set[4] = bus.in_valid & w_full;
        if (w_push) begin
            case (w_enc_class)
                CLS_ZERO:  w_sts_set[0] = 1'b1;
                CLS_UFLOW: w_sts_set[1] = 1'b1;
                CLS_INF:   w_sts_set[2] = 1'b1;
                CLS_NAN:   w_sts_set[3] = 1'b1;
                default:   w_sts_set    = w_sts_set;
            endcase
        end
    end

    // Sticky status; a same-cycle set overrides the clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sts <= '0;
        end else begin
            r_sts <= (clr_sts ? 5'b0 : r_sts) | w_sts_set;
        end
    end

    // Accepted-result counter, wraps at 2^CNT_W
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_res_cnt <= '0;
        end else if (w_push) begin
            r_res_cnt <= r_res_cnt + CNT_W'(1);
        end
    end

    assign sts     = r_sts;
    assign res_cnt = r_res_cnt;

endmodule
`default_nettype wire
